// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundle of signals between the functional-unit result ports and the
// common-data-bus arbiter.
//
//   fu_valid_in    [NUM_FU]        per-port result valid
//   fu_rob_ix_in   [NUM_FU*ROB_W]  packed ROB index, port i at [i*ROB_W +: ROB_W]
//   fu_value_in    [NUM_FU*32]     packed signed result, port i at [i*32 +: 32]
//   fu_ready_out   [NUM_FU]        per-port buffer can accept a result
//   cdb_valid_out                  CDB broadcast valid
//   cdb_rob_ix_out [ROB_W]         broadcast ROB index
//   cdb_value_out  [32]            broadcast signed value
//   cdb_src_out    [SRC_W]         port that produced the broadcast
//
// Modports: master = functional-unit side, slave = arbiter.
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
  parameter int NUM_FU = 3,
  parameter int ROB_W  = 3
);
  localparam int SRC_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]       fu_valid_in;
  logic [NUM_FU*ROB_W-1:0] fu_rob_ix_in;
  logic [NUM_FU*32-1:0]    fu_value_in;
  logic [NUM_FU-1:0]       fu_ready_out;
  logic                    cdb_valid_out;
  logic [ROB_W-1:0]        cdb_rob_ix_out;
  logic signed [31:0]      cdb_value_out;
  logic [SRC_W-1:0]        cdb_src_out;

  modport master (
    output fu_valid_in, fu_rob_ix_in, fu_value_in,
    input  fu_ready_out, cdb_valid_out, cdb_rob_ix_out, cdb_value_out, cdb_src_out
  );

  modport slave (
    input  fu_valid_in, fu_rob_ix_in, fu_value_in,
    output fu_ready_out, cdb_valid_out, cdb_rob_ix_out, cdb_value_out, cdb_src_out
  );
endinterface

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Common-data-bus arbiter. Each functional-unit port owns a small result FIFO;
// one result per cycle is granted round-robin among the non-empty FIFOs and
// registered onto the CDB outputs.
//
// Ports:
//   clk_in    sole clock, rising edge
//   rst_n_in  asynchronous active-low reset
//   flush_in  synchronous flush: drops every buffered result, rr pointer to 0
//   bus       cdb_arbiter_if.slave (FU result inputs, ready, CDB outputs)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_FU     = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int ROB_W      = 3
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            flush_in,
  cdb_arbiter_if.slave    bus
);

  localparam int SRC_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = ROB_W + 32;

  // Per-port FIFO status, collected from the generate blocks
  logic [NUM_FU-1:0] nonempty;
  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] pop;
  logic [ENT_W-1:0]  head [NUM_FU];

  // Arbitration result
  logic              grant_valid;
  logic [SRC_W-1:0]  grant_ix;
  logic [SRC_W:0]    scan_ix;

  // CDB output and round-robin state
  logic              cdb_valid_q, cdb_valid_d;
  logic [ROB_W-1:0]  cdb_rob_ix_q, cdb_rob_ix_d;
  logic [31:0]       cdb_value_q, cdb_value_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;

  // ---------------------------------------------------------------------------
  // Per-port result FIFOs
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_port
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic             push;

    // Ready comes from registered occupancy only; a full FIFO that is being
    // popped this cycle still reports not-ready. Forced low during reset.
    assign ready[gi]    = rst_n_in && (count_q != CNT_W'(FIFO_DEPTH));
    assign nonempty[gi] = (count_q != '0);
    assign head[gi]     = mem_q[rd_ptr_q];
    assign push         = bus.fu_valid_in[gi] && ready[gi] && !flush_in;
    assign pop[gi]      = grant_valid && (grant_ix == SRC_W'(gi)) && !flush_in;

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_in) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        // Depth is a power of two, so pointers wrap naturally
        if (push)    wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop[gi]) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop[gi])      count_d = count_q + CNT_W'(1);
        else if (!push && pop[gi]) count_d = count_q - CNT_W'(1);
      end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk_in) begin
      if (push) begin
        mem_q[wr_ptr_q] <= {bus.fu_rob_ix_in[gi*ROB_W +: ROB_W],
                            bus.fu_value_in[gi*32 +: 32]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin grant: first non-empty port scanning from rr_ptr upward,
  // wrapping modulo NUM_FU (which need not be a power of two).
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_valid = 1'b0;
    grant_ix    = '0;
    scan_ix     = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan_ix = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (scan_ix >= (SRC_W+1)'(NUM_FU)) scan_ix = scan_ix - (SRC_W+1)'(NUM_FU);
      if (!grant_valid && nonempty[scan_ix[SRC_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_ix    = scan_ix[SRC_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // CDB output register and round-robin pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    cdb_valid_d  = 1'b0;
    cdb_rob_ix_d = cdb_rob_ix_q;
    cdb_value_d  = cdb_value_q;
    cdb_src_d    = cdb_src_q;
    rr_ptr_d     = rr_ptr_q;
    if (flush_in) begin
      rr_ptr_d = '0;
    end else if (grant_valid) begin
      cdb_valid_d                 = 1'b1;
      {cdb_rob_ix_d, cdb_value_d} = head[grant_ix];
      cdb_src_d                   = grant_ix;
      rr_ptr_d = (grant_ix == SRC_W'(NUM_FU - 1)) ? '0 : grant_ix + SRC_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cdb_valid_q  <= 1'b0;
      cdb_rob_ix_q <= '0;
      cdb_value_q  <= '0;
      cdb_src_q    <= '0;
      rr_ptr_q     <= '0;
    end else begin
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_ix_q <= cdb_rob_ix_d;
      cdb_value_q  <= cdb_value_d;
      cdb_src_q    <= cdb_src_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign bus.fu_ready_out   = ready;
  assign bus.cdb_valid_out  = cdb_valid_q;
  assign bus.cdb_rob_ix_out = cdb_rob_ix_q;
  assign bus.cdb_value_out  = cdb_value_q;
  assign bus.cdb_src_out    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed scenarios plus a randomized run for cdb_arbiter. A queue-per-port
// reference model tracks buffered results, the round-robin pointer and the
// expected CDB outputs; it advances once per clock edge inside step().
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
  localparam int NUM_FU     = 3;
  localparam int FIFO_DEPTH = 2;
  localparam int ROB_W      = 3;

  logic clk;
  logic rst_n;
  logic flush;

  cdb_arbiter_if #(.NUM_FU(NUM_FU), .ROB_W(ROB_W)) bus ();

  cdb_arbiter #(.NUM_FU(NUM_FU), .FIFO_DEPTH(FIFO_DEPTH), .ROB_W(ROB_W)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .flush_in (flush),
    .bus      (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  typedef logic [ROB_W+31:0] ent_t;
  typedef ent_t ent_q_t [$];
  ent_q_t             mq [NUM_FU];
  int                 m_rr;
  logic               m_valid;
  logic [ROB_W-1:0]   m_rob;
  logic [31:0]        m_val;
  int                 m_src;
  logic               m_in_reset;

  function automatic logic [NUM_FU-1:0] exp_ready();
    logic [NUM_FU-1:0] r;
    for (int p = 0; p < NUM_FU; p++) r[p] = !m_in_reset && (mq[p].size() != FIFO_DEPTH);
    return r;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NUM_FU; p++) mq[p].delete();
    m_rr = 0; m_valid = 1'b0; m_rob = '0; m_val = '0; m_src = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, and return
  // 1 time unit after the rising edge with inputs back to idle.
  task automatic step(input logic [NUM_FU-1:0] v, input logic [NUM_FU*ROB_W-1:0] rob,
                      input logic [NUM_FU*32-1:0] val, input logic fl);
    int g;
    logic [NUM_FU-1:0] rdy;
    ent_t e;
    bus.fu_valid_in  = v;
    bus.fu_rob_ix_in = rob;
    bus.fu_value_in  = val;
    flush            = fl;
    rdy = exp_ready();
    g = -1;
    for (int k = 0; k < NUM_FU; k++) begin
      int p;
      p = (m_rr + k) % NUM_FU;
      if (g < 0 && mq[p].size() != 0) g = p;
    end
    if (fl) begin
      for (int p = 0; p < NUM_FU; p++) mq[p].delete();
      m_rr = 0;
      m_valid = 1'b0;
    end else begin
      if (g >= 0) begin
        e = mq[g].pop_front();
        m_valid = 1'b1;
        m_rob = e[ROB_W+31:32];
        m_val = e[31:0];
        m_src = g;
        m_rr = (g + 1) % NUM_FU;
      end else begin
        m_valid = 1'b0;
      end
      for (int p = 0; p < NUM_FU; p++)
        if (v[p] && rdy[p]) mq[p].push_back({rob[p*ROB_W +: ROB_W], val[p*32 +: 32]});
    end
    @(posedge clk);
    #1;
    bus.fu_valid_in = '0;
    flush = 1'b0;
    if (bus.cdb_valid_out === 1'b1)
      $display("bcast src=%0d rob=%0d value=%0d", bus.cdb_src_out, bus.cdb_rob_ix_out, bus.cdb_value_out);
  endtask

  task automatic idle();
    step('0, '0, '0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b1; flush = 1'b0;
    bus.fu_valid_in = '0; bus.fu_rob_ix_in = '0; bus.fu_value_in = '0;
    #2 rst_n = 1'b0;
    model_reset(); m_in_reset = 1'b1;
    #1;
    n_checks++; if (bus.cdb_valid_out !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", bus.cdb_valid_out); end
    n_checks++; if (bus.fu_ready_out !== 3'b000) begin n_errors++; $display("FAIL reset_ready: got %b expected 000", bus.fu_ready_out); end
    n_checks++; if (bus.cdb_rob_ix_out !== 3'd0 || bus.cdb_value_out !== 32'sd0 || bus.cdb_src_out !== 2'd0) begin
      n_errors++; $display("FAIL reset_data: got rob=%0d value=%0d src=%0d expected all 0", bus.cdb_rob_ix_out, bus.cdb_value_out, bus.cdb_src_out); end
    // Valid inputs during reset must be ignored
    bus.fu_valid_in = 3'b111;
    @(posedge clk); @(posedge clk); #1;
    bus.fu_valid_in = '0;
    n_checks++; if (bus.fu_ready_out !== 3'b000) begin n_errors++; $display("FAIL reset_ready_clocked: got %b expected 000", bus.fu_ready_out); end
    @(negedge clk);
    rst_n = 1'b1; m_in_reset = 1'b0;
    idle();
    n_checks++; if (bus.fu_ready_out !== 3'b111) begin n_errors++; $display("FAIL release_ready: got %b expected 111", bus.fu_ready_out); end
    n_checks++; if (bus.cdb_valid_out !== 1'b0) begin n_errors++; $display("FAIL release_valid: got %b expected 0", bus.cdb_valid_out); end
  endtask

  task automatic test_single();
    step(3'b010, {3'd0, 3'd5, 3'd0}, {32'd0, 32'hFFFF_FFF9, 32'd0}, 1'b0);
    n_checks++; if (bus.cdb_valid_out !== 1'b0) begin n_errors++; $display("FAIL single_no_bypass: got valid=%b expected 0", bus.cdb_valid_out); end
    idle();
    n_checks++; if (bus.cdb_valid_out !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %b expected 1", bus.cdb_valid_out); end
    n_checks++; if (bus.cdb_rob_ix_out !== 3'd5) begin n_errors++; $display("FAIL single_rob: got %0d expected 5", bus.cdb_rob_ix_out); end
    n_checks++; if (bus.cdb_value_out !== -32'sd7) begin n_errors++; $display("FAIL single_value: got %0d expected -7", bus.cdb_value_out); end
    n_checks++; if (bus.cdb_src_out !== 2'd1) begin n_errors++; $display("FAIL single_src: got %0d expected 1", bus.cdb_src_out); end
    idle();
    n_checks++; if (bus.cdb_valid_out !== 1'b0) begin n_errors++; $display("FAIL single_one_cycle: got valid=%b expected 0", bus.cdb_valid_out); end
  endtask

  task automatic test_contention();
    step('0, '0, '0, 1'b1);   // flush brings rr_ptr to 0
    step(3'b111, {3'd3, 3'd2, 3'd1}, {32'd300, 32'd200, 32'd100}, 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle();
      n_checks++; if (bus.cdb_valid_out !== 1'b1 || bus.cdb_src_out !== 2'(k)) begin
        n_errors++; $display("FAIL contention_src%0d: got valid=%b src=%0d expected valid=1 src=%0d", k, bus.cdb_valid_out, bus.cdb_src_out, k); end
      n_checks++; if (bus.cdb_rob_ix_out !== 3'(k + 1) || bus.cdb_value_out !== 32'(100 * (k + 1))) begin
        n_errors++; $display("FAIL contention_data%0d: got rob=%0d value=%0d expected rob=%0d value=%0d", k, bus.cdb_rob_ix_out, bus.cdb_value_out, k + 1, 100 * (k + 1)); end
    end
    idle();
    n_checks++; if (bus.cdb_valid_out !== 1'b0) begin n_errors++; $display("FAIL contention_drain: got valid=%b expected 0", bus.cdb_valid_out); end
  endtask

  task automatic test_full();
    step('0, '0, '0, 1'b1);
    step(3'b111, {3'd3, 3'd1, 3'd0}, {32'd33, 32'd11, 32'd10}, 1'b0);
    step(3'b100, {3'd4, 6'd0}, {32'd44, 64'd0}, 1'b0);   // port 2 now holds two
    n_checks++; if (bus.fu_ready_out[2] !== 1'b0) begin n_errors++; $display("FAIL full_ready_low: got %b expected 0", bus.fu_ready_out[2]); end
    n_checks++; if (bus.cdb_valid_out !== 1'b1 || bus.cdb_src_out !== 2'd0) begin n_errors++; $display("FAIL full_first_grant: got valid=%b src=%0d expected 1/0", bus.cdb_valid_out, bus.cdb_src_out); end
    step(3'b100, {3'd5, 6'd0}, {32'd55, 64'd0}, 1'b0);   // ignored: not ready
    n_checks++; if (bus.fu_ready_out[2] !== 1'b0) begin n_errors++; $display("FAIL full_ready_hold: got %b expected 0", bus.fu_ready_out[2]); end
    idle();
    n_checks++; if (bus.cdb_src_out !== 2'd2 || bus.cdb_rob_ix_out !== 3'd3 || bus.cdb_value_out !== 32'sd33) begin
      n_errors++; $display("FAIL full_order_first: got src=%0d rob=%0d value=%0d expected 2/3/33", bus.cdb_src_out, bus.cdb_rob_ix_out, bus.cdb_value_out); end
    n_checks++; if (bus.fu_ready_out[2] !== 1'b1) begin n_errors++; $display("FAIL full_ready_return: got %b expected 1", bus.fu_ready_out[2]); end
    idle();
    n_checks++; if (bus.cdb_valid_out !== 1'b1 || bus.cdb_rob_ix_out !== 3'd4 || bus.cdb_value_out !== 32'sd44) begin
      n_errors++; $display("FAIL full_order_second: got valid=%b rob=%0d value=%0d expected 1/4/44", bus.cdb_valid_out, bus.cdb_rob_ix_out, bus.cdb_value_out); end
    idle();
    n_checks++; if (bus.cdb_valid_out !== 1'b0) begin n_errors++; $display("FAIL full_ignored_push: got valid=%b rob=%0d expected valid 0", bus.cdb_valid_out, bus.cdb_rob_ix_out); end
  endtask

  task automatic test_fairness();
    step('0, '0, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(3'b011, {3'd0, 3'(i + 2), 3'(i + 1)}, {32'd0, 32'(1000 + i), 32'(500 + i)}, 1'b0);
      if (i > 0) begin
        n_checks++; if (bus.cdb_valid_out !== 1'b1 || bus.cdb_src_out !== 2'((i - 1) % 2)) begin
          n_errors++; $display("FAIL fair_alternate%0d: got valid=%b src=%0d expected 1/%0d", i, bus.cdb_valid_out, bus.cdb_src_out, (i - 1) % 2); end
        n_checks++; if (bus.cdb_rob_ix_out !== m_rob || bus.cdb_value_out !== m_val) begin
          n_errors++; $display("FAIL fair_data%0d: got rob=%0d value=%0d expected rob=%0d value=%0d", i, bus.cdb_rob_ix_out, bus.cdb_value_out, m_rob, m_val); end
      end
    end
  endtask

  task automatic test_flush();
    step('0, '0, '0, 1'b1);
    step(3'b111, {3'd3, 3'd2, 3'd1}, {32'd3, 32'd2, 32'd1}, 1'b0);
    step(3'b011, {3'd0, 3'd6, 3'd5}, {32'd0, 32'd6, 32'd5}, 1'b0);   // four now buffered
    step(3'b111, {3'd7, 3'd7, 3'd7}, {32'd777, 32'd777, 32'd777}, 1'b1);
    n_checks++; if (bus.cdb_valid_out !== 1'b0) begin n_errors++; $display("FAIL flush_valid: got %b expected 0", bus.cdb_valid_out); end
    n_checks++; if (bus.fu_ready_out !== 3'b111) begin n_errors++; $display("FAIL flush_ready: got %b expected 111", bus.fu_ready_out); end
    for (int i = 0; i < 4; i++) begin
      idle();
      n_checks++; if (bus.cdb_valid_out !== 1'b0) begin n_errors++; $display("FAIL flush_drop%0d: got valid=%b rob=%0d expected valid 0", i, bus.cdb_valid_out, bus.cdb_rob_ix_out); end
    end
  endtask

  task automatic test_async_reset();
    step('0, '0, '0, 1'b1);
    step(3'b111, {3'd6, 3'd5, 3'd4}, {32'd9, 32'd8, 32'd7}, 1'b0);
    idle();   // port 0 broadcast, two results still buffered
    #2 rst_n = 1'b0;
    model_reset(); m_in_reset = 1'b1;
    #1;
    n_checks++; if (bus.cdb_valid_out !== 1'b0) begin n_errors++; $display("FAIL async_valid: got %b expected 0", bus.cdb_valid_out); end
    n_checks++; if (bus.cdb_rob_ix_out !== 3'd0 || bus.cdb_value_out !== 32'sd0 || bus.cdb_src_out !== 2'd0) begin
      n_errors++; $display("FAIL async_data: got rob=%0d value=%0d src=%0d expected all 0", bus.cdb_rob_ix_out, bus.cdb_value_out, bus.cdb_src_out); end
    n_checks++; if (bus.fu_ready_out !== 3'b000) begin n_errors++; $display("FAIL async_ready: got %b expected 000", bus.fu_ready_out); end
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1; m_in_reset = 1'b0;
    idle();
    n_checks++; if (bus.fu_ready_out !== 3'b111) begin n_errors++; $display("FAIL async_release_ready: got %b expected 111", bus.fu_ready_out); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.cdb_valid_out !== 1'b0) begin n_errors++; $display("FAIL async_no_bcast%0d: got valid=%b expected 0", i, bus.cdb_valid_out); end
      idle();
    end
  endtask

  task automatic test_random();
    logic [NUM_FU-1:0]       v;
    logic [NUM_FU*ROB_W-1:0] rob;
    logic [NUM_FU*32-1:0]    val;
    logic                    fl;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
      rob = 9'($urandom);
      val = {$urandom, $urandom, $urandom};
      fl  = ($urandom_range(0, 31) == 0);
      step(v, rob, val, fl);
      n_checks++; if (bus.fu_ready_out !== exp_ready()) begin n_errors++; $display("FAIL rand_ready@%0d: got %b expected %b", i, bus.fu_ready_out, exp_ready()); end
      n_checks++; if (bus.cdb_valid_out !== m_valid) begin n_errors++; $display("FAIL rand_valid@%0d: got %b expected %b", i, bus.cdb_valid_out, m_valid); end
      n_checks++; if (bus.cdb_rob_ix_out !== m_rob) begin n_errors++; $display("FAIL rand_rob@%0d: got %0d expected %0d", i, bus.cdb_rob_ix_out, m_rob); end
      n_checks++; if (bus.cdb_value_out !== m_val) begin n_errors++; $display("FAIL rand_value@%0d: got %0h expected %0h", i, bus.cdb_value_out, m_val); end
      n_checks++; if (bus.cdb_src_out !== 2'(m_src)) begin n_errors++; $display("FAIL rand_src@%0d: got %0d expected %0d", i, bus.cdb_src_out, m_src); end
    end
  endtask

  initial begin
    m_in_reset = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_fairness();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got time %0t expected under 100000", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 3: number of functional-unit result ports.
REQ-002 Parameter FIFO_DEPTH, default 2: result buffer entries per port, power of two, at least 2.
REQ-003 Parameter ROB_W, default 3: ROB index width (8-entry ROB).
REQ-004 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-005 clk_in  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n_in  input  1  asynchronous active-low reset.
REQ-007 flush_in  input  1  synchronous pipeline flush (mispredict); discards all buffered results.
REQ-008 fu_valid_in  input  NUM_FU  per-port result valid.
REQ-009 fu_rob_ix_in  input  NUM_FU*ROB_W  packed ROB index per port; port i at bits [i*ROB_W +: ROB_W].
REQ-010 fu_value_in  input  NUM_FU*32  packed signed result per port; port i at bits [i*32 +: 32].
REQ-011 fu_ready_out  output  NUM_FU  per-port buffer can accept a result this cycle.
REQ-012 cdb_valid_out  output  1  CDB broadcast valid.
REQ-013 cdb_rob_ix_out  output  ROB_W  ROB index being broadcast.
REQ-014 cdb_value_out  output  32  signed value being broadcast.
REQ-015 cdb_src_out  output  $clog2(NUM_FU)  index of the port that produced the broadcast.

Function
REQ-016 Each port SHALL own a FIFO of FIFO_DEPTH entries, each entry holding {rob_ix, value}.
REQ-017 fu_ready_out[i] SHALL equal (count[i] != FIFO_DEPTH) and SHALL be driven 0 while rst_n_in is low.
- fu_ready_out[i] depends only on registered state, not on fu_valid_in or the same-cycle pop.
- A full FIFO being popped this cycle still shows ready = 0.
REQ-018 A push on port i SHALL occur at a rising edge where fu_valid_in[i] && fu_ready_out[i] && !flush_in.
- Data is captured in order at the write pointer.
- With fu_ready_out[i] = 0, fu_valid_in[i] SHALL be ignored.
REQ-019 Arbitration SHALL be combinational over registered FIFO state: grant the first non-empty port scanning rr_ptr, rr_ptr+1, ... modulo NUM_FU.
REQ-020 On a grant with !flush_in, at the rising edge:
- the head of the granted FIFO is popped;
- its fields are registered onto cdb_rob_ix_out and cdb_value_out;
- cdb_src_out is set to the granted index;
- cdb_valid_out is set to 1;
- rr_ptr is set to (grant+1) mod NUM_FU.
REQ-021 With no non-empty FIFO, cdb_valid_out SHALL go 0 at the edge, and rr_ptr and the data outputs SHALL hold their values.
REQ-022 At most one result SHALL be broadcast per cycle, and each accepted result SHALL be broadcast exactly once, with cdb_valid_out high for exactly one cycle.
REQ-023 Latency: a result pushed at edge N SHALL appear with cdb_valid_out = 1 no earlier than the cycle after edge N+1. There is no bypass from input to CDB.
REQ-024 A push and a pop on the same port in the same cycle SHALL both take effect, leaving count unchanged.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH.
- count SHALL never exceed FIFO_DEPTH.
- count SHALL never underflow.
REQ-026 Per-port order SHALL be preserved. Cross-port order is defined only by the round-robin grant.
REQ-027 Starvation bound: a non-empty port SHALL be granted within NUM_FU consecutive broadcast cycles.
REQ-028 flush_in = 1 at an edge SHALL take priority over pushes and pops:
- all counts and pointers cleared;
- rr_ptr set to 0;
- cdb_valid_out set to 0;
- no push and no pop take effect in that cycle.

Reset
REQ-029 While rst_n_in = 0, independent of clk_in:
- all FIFOs empty and rr_ptr = 0;
- cdb_valid_out = 0, cdb_rob_ix_out = 0, cdb_value_out = 0, cdb_src_out = 0;
- fu_ready_out = 0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered results. After release, no broadcast SHALL occur until a new push.
REQ-031 On the first edge after release, fu_ready_out SHALL read all-ones.

Verification
REQ-032 Single result: port 1 pushes rob 5, value -7 at edge N -> at edge N+1, cdb_valid_out = 1, rob 5, value -7, src 1, high for one cycle only.
REQ-033 Contention: all 3 ports push at the same edge with rr_ptr = 0 -> broadcasts come from src 0, 1, 2 on consecutive cycles, then cdb_valid_out = 0.
REQ-034 Full/backpressure: port 2 pushes twice with no grant possible -> fu_ready_out[2] = 0. A third valid is ignored. Ready returns to 1 the cycle after the first pop. Order is preserved: rob 3 before rob 4.
REQ-035 Fairness: ports 0 and 1 kept continuously non-empty -> grants alternate 0, 1, 0, 1, and neither port waits more than 3 broadcasts.
REQ-036 Flush: 4 results buffered and flush_in pulsed with a concurrent push -> the next cycle has cdb_valid_out = 0 and all fu_ready_out = 1. The concurrent push is never broadcast.
REQ-037 Async reset: rst_n_in driven low between clock edges while results are buffered -> outputs go to 0 immediately. After release, zero broadcasts occur.
